// File: rtl/switch_alloc_credit.sv
// switch_alloc_credit: credit-based switch allocator for an NPORTS router.
// Each output runs its own round-robin arbiter over the inputs that carry a
// one-hot label for it. An output competes only while it holds downstream
// credits. The winning flit is registered onto the output one cycle later.
module switch_alloc_credit #(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40,
    parameter int CREDITS  = 8,
    localparam int CW = $clog2(CREDITS + 1),
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            in_valid,
    input  logic [NPORTS*NPORTS-1:0]     in_dst,
    input  logic [NPORTS*DATASIZE-1:0]   in_data,
    output logic [NPORTS-1:0]            in_ready,
    input  logic [NPORTS-1:0]            credit_in,
    output logic [NPORTS-1:0]            out_valid,
    output logic [NPORTS*DATASIZE-1:0]   out_data,
    output logic [NPORTS*CW-1:0]         credit_cnt,
    output logic [1:0]                   err
);

    logic [NPORTS-1:0][PW-1:0]       ptr_q, ptr_d;
    logic [NPORTS-1:0][CW-1:0]       cnt_q, cnt_d;
    logic [NPORTS-1:0]               vld_q, vld_d;
    logic [NPORTS-1:0][DATASIZE-1:0] data_q, data_d;
    logic [1:0]                      err_q, err_d;

    logic [NPORTS-1:0]               lbl_ok;  // label of input i is exactly one-hot
    logic [NPORTS-1:0][NPORTS-1:0]   req;     // req[j][i]: input i wants output j
    logic [NPORTS-1:0][NPORTS-1:0]   gnt;     // gnt[j][i]: output j grants input i
    logic [NPORTS-1:0][PW-1:0]       win;     // winning input index per output

    // Decode destination labels into per-output request vectors
    always_comb begin
        logic [NPORTS-1:0] d;
        d      = '0;
        lbl_ok = '0;
        req    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            d         = in_dst[i*NPORTS +: NPORTS];
            lbl_ok[i] = (d != '0) && ((d & (d - NPORTS'(1))) == '0);
            for (int j = 0; j < NPORTS; j++)
                req[j][i] = in_valid[i] & lbl_ok[i] & d[j];
        end
    end

    // Round-robin search per output, starting at its pointer, gated by credits
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        win   = '0;
        for (int j = 0; j < NPORTS; j++) begin
            found = 1'b0;
            if (cnt_q[j] != '0) begin
                for (int k = 0; k < NPORTS; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= NPORTS) idx = idx - NPORTS;
                    if (!found && req[j][idx]) begin
                        found       = 1'b1;
                        gnt[j][idx] = 1'b1;
                        win[j]      = PW'(idx);
                    end
                end
            end
        end
    end

    // Pop strobe back to the inputs; suppressed while reset is held so no
    // flit is consumed that the output registers would then drop
    always_comb begin
        in_ready = '0;
        for (int j = 0; j < NPORTS; j++)
            in_ready = in_ready | gnt[j];
        if (rst) in_ready = '0;
    end

    // Next state: output flit, pointer advance, credit accounting, sticky errors
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        vld_d  = '0;
        err_d  = err_q;
        for (int i = 0; i < NPORTS; i++)
            if (in_valid[i] && !lbl_ok[i]) err_d[0] = 1'b1;
        for (int j = 0; j < NPORTS; j++) begin
            if (|gnt[j]) begin
                vld_d[j]  = 1'b1;
                data_d[j] = in_data[int'(win[j])*DATASIZE +: DATASIZE];
                ptr_d[j]  = (int'(win[j]) == NPORTS - 1) ? '0 : win[j] + PW'(1);
            end
            // Grant and returning credit in the same cycle cancel out
            case ({|gnt[j], credit_in[j]})
                2'b10: cnt_d[j] = cnt_q[j] - CW'(1);
                2'b01: begin
                    if (cnt_q[j] == CW'(CREDITS)) err_d[1] = 1'b1;
                    else                          cnt_d[j] = cnt_q[j] + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            cnt_q  <= {NPORTS{CW'(CREDITS)}};
            vld_q  <= '0;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign credit_cnt = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_switch_alloc_credit.sv
// Bench for switch_alloc_credit: a cycle model predicts grants, which are
// queued as expected output flits and popped when the outputs are sampled.
module tb_switch_alloc_credit;

    localparam int NP = 5;
    localparam int DW = 40;
    localparam int CR = 8;
    localparam int CW = $clog2(CR + 1);

    logic                clk;
    logic                rst;
    logic [NP-1:0]       in_valid;
    logic [NP*NP-1:0]    in_dst;
    logic [NP*DW-1:0]    in_data;
    logic [NP-1:0]       in_ready;
    logic [NP-1:0]       credit_in;
    logic [NP-1:0]       out_valid;
    logic [NP*DW-1:0]    out_data;
    logic [NP*CW-1:0]    credit_cnt;
    logic [1:0]          err;

    switch_alloc_credit #(.NPORTS(NP), .DATASIZE(DW), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst),
        .in_data(in_data), .in_ready(in_ready), .credit_in(credit_in),
        .out_valid(out_valid), .out_data(out_data), .credit_cnt(credit_cnt),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sbq[$];
    int            m_ptr[NP];
    int            m_cnt[NP];
    logic [DW-1:0] m_last[NP];
    logic [1:0]    m_err;
    logic [NP-1:0] last_rdy;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] dst_of(input int i);
        return in_dst[i*NP +: NP];
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NP; j++) begin
            m_ptr[j]  = 0;
            m_cnt[j]  = CR;
            m_last[j] = '0;
        end
        m_err = '0;
        sbq.delete();
    endtask

    task automatic clr_in();
        in_valid  = '0;
        in_dst    = '0;
        in_data   = '0;
        credit_in = '0;
    endtask

    task automatic set_in(input int i, input int j, input logic [DW-1:0] d);
        in_valid[i]         = 1'b1;
        in_dst[i*NP +: NP]  = NP'(1) << j;
        in_data[i*DW +: DW] = d;
    endtask

    // One clock: predict and check grants, advance model, check registered outputs
    task automatic step();
        int            win[NP];
        int            best;
        int            d;
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_v;
        logic [NP*CW-1:0] expc;
        sb_t           e;
        logic          g;
        logic          c;
        #1;
        exp_rdy = '0;
        for (int j = 0; j < NP; j++) begin
            win[j] = -1;
            best   = NP;
            if (m_cnt[j] > 0) begin
                for (int i = 0; i < NP; i++) begin
                    if (in_valid[i] && dst_of(i) == (NP'(1) << j)) begin
                        d = (i - m_ptr[j] + NP) % NP;
                        if (d < best) begin
                            best   = d;
                            win[j] = i;
                        end
                    end
                end
            end
            if (win[j] >= 0) exp_rdy[win[j]] = 1'b1;
        end
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        last_rdy = in_ready;
        for (int j = 0; j < NP; j++) begin
            g = (win[j] >= 0);
            c = credit_in[j];
            if (g) begin
                e.port = j;
                e.data = in_data[win[j]*DW +: DW];
                sbq.push_back(e);
                m_last[j] = e.data;
                m_ptr[j]  = (win[j] + 1) % NP;
            end
            if (g && !c) m_cnt[j] = m_cnt[j] - 1;
            else if (!g && c) begin
                if (m_cnt[j] == CR) m_err[1] = 1'b1;
                else                m_cnt[j] = m_cnt[j] + 1;
            end
        end
        for (int i = 0; i < NP; i++)
            if (in_valid[i] && $countones(dst_of(i)) != 1) m_err[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_v = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            exp_v[e.port] = 1'b1;
            chk("out_data", 64'(out_data[e.port*DW +: DW]), 64'(e.data));
        end
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        for (int j = 0; j < NP; j++) begin
            if (!exp_v[j]) chk("out_hold", 64'(out_data[j*DW +: DW]), 64'(m_last[j]));
            expc[j*CW +: CW] = CW'(m_cnt[j]);
        end
        chk("credit_cnt", 64'(credit_cnt), 64'(expc));
        chk("err", 64'(err), 64'(m_err));
    endtask

    // Hold reset across an edge with live requests; check the reset image
    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        set_in(0, 0, 40'h1);
        set_in(2, 3, 40'h2);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data_nz", 64'(|out_data), 64'd0);
        chk("rst_credit_cnt", 64'(credit_cnt), 64'({NP{4'd8}}));
        chk("rst_err", 64'(err), 64'd0);
        model_reset();
        rst = 1'b0;
        clr_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int            exp_seq[8];
        logic [63:0]   r64;
        checks = 0;
        errors = 0;
        exp_seq = '{0, 1, 3, 0, 1, 3, 0, 1};
        clr_in();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // single flow 1 -> 2
        set_in(1, 2, 40'hA5);
        step();
        chk("sf_rdy", 64'(last_rdy), 64'h02);
        chk("sf_data", 64'(out_data[2*DW +: DW]), 64'hA5);
        chk("sf_cnt2", 64'(credit_cnt[2*CW +: CW]), 64'd7);
        clr_in();
        step();

        // full permutation: every input granted in the same cycle
        for (int i = 0; i < NP; i++) set_in(i, (i + 1) % NP, 40'h100 + DW'(i));
        step();
        chk("perm_rdy", 64'(last_rdy), 64'h1F);

        // contention on output 4 until credits run out
        do_reset();
        set_in(0, 4, 40'h10);
        set_in(1, 4, 40'h11);
        set_in(3, 4, 40'h13);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("cont_gnt", 64'(last_rdy), 64'(NP'(1) << exp_seq[k]));
        end
        step();
        chk("stall_rdy", 64'(last_rdy), 64'd0);
        chk("stall_cnt4", 64'(credit_cnt[4*CW +: CW]), 64'd0);

        // one returned credit buys exactly one grant, to input 3
        credit_in[4] = 1'b1;
        step();
        chk("cr_pulse_rdy", 64'(last_rdy), 64'd0);
        credit_in = '0;
        step();
        chk("cr_gnt3", 64'(last_rdy), 64'h08);
        chk("cr_cnt4", 64'(credit_cnt[4*CW +: CW]), 64'd0);
        step();
        chk("cr_stall", 64'(last_rdy), 64'd0);

        // asynchronous reset in the middle of contention
        do_reset();
        set_in(0, 4, 40'h30);
        set_in(1, 4, 40'h31);
        set_in(3, 4, 40'h33);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_credit_cnt", 64'(credit_cnt), 64'({NP{4'd8}}));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mr_first", 64'(last_rdy), 64'h01);

        // grant and credit together at count 1
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in(0, 2, 40'h20 + DW'(k));
            step();
        end
        chk("gc_pre_cnt2", 64'(credit_cnt[2*CW +: CW]), 64'd1);
        credit_in[2] = 1'b1;
        step();
        chk("gc_rdy", 64'(last_rdy), 64'h01);
        chk("gc_cnt2", 64'(credit_cnt[2*CW +: CW]), 64'd1);
        credit_in = '0;
        step();
        chk("gc_next_rdy", 64'(last_rdy), 64'h01);
        chk("gc_next_cnt2", 64'(credit_cnt[2*CW +: CW]), 64'd0);

        // illegal label and credit overflow, both sticky
        do_reset();
        in_valid[0]   = 1'b1;
        in_dst[0 +: NP] = 5'b00110;
        in_data[0 +: DW] = 40'hBAD;
        credit_in[3]  = 1'b1;
        step();
        chk("err_rdy", 64'(last_rdy), 64'd0);
        chk("err_bits", 64'(err), 64'd3);
        chk("err_cnt3", 64'(credit_cnt[3*CW +: CW]), 64'd8);
        clr_in();
        repeat (3) step();
        chk("err_sticky", 64'(err), 64'd3);

        // random traffic
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NP; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) in_dst[i*NP +: NP] = NP'($urandom());
                else                            in_dst[i*NP +: NP] = NP'(1) << $urandom_range(0, NP - 1);
                r64 = {$urandom(), $urandom()};
                in_data[i*DW +: DW] = r64[DW-1:0];
                credit_in[i] = ($urandom_range(0, 9) < 4);
            end
            step();
        end
        clr_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_alloc_credit.md
SWITCH_ALLOC_CREDIT -- requirements
Module: switch_alloc_credit

Interface
REQ-001 SHALL have parameter NPORTS, default 5, number of router ports (0=L,1=N,2=E,3=S,4=W at default).
REQ-002 SHALL have parameter DATASIZE, default 40, flit width.
REQ-003 SHALL have parameter CREDITS, default 8, downstream buffer depth per output; CW=clog2(CREDITS+1).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  NPORTS  input FIFO i non-empty.
REQ-007 SHALL have port in_dst  input  NPORTS*NPORTS  one-hot destination label of input i, slice [i*NPORTS +: NPORTS].
REQ-008 SHALL have port in_data  input  NPORTS*DATASIZE  head flit of input i.
REQ-009 SHALL have port in_ready  output  NPORTS  combinational grant to input i; pops input FIFO.
REQ-010 SHALL have port credit_in  input  NPORTS  one-cycle pulse, downstream of output j freed one slot.
REQ-011 SHALL have port out_valid  output  NPORTS  registered flit valid on output j.
REQ-012 SHALL have port out_data  output  NPORTS*DATASIZE  registered flit on output j.
REQ-013 SHALL have port credit_cnt  output  NPORTS*CW  current credit count per output.
REQ-014 SHALL have port err  output  2  sticky: bit0 illegal label, bit1 credit overflow.

Function
REQ-015 Input i SHALL request output j iff in_valid[i] and in_dst[i] is exactly one-hot with bit j set.
REQ-016 in_valid[i] with in_dst[i] zero or multi-hot SHALL raise no request, set err[0], and never be granted.
REQ-017 Output j SHALL be eligible only when credit_cnt[j] != 0.
REQ-018 Each output SHALL own a round-robin pointer ptr[j]; search starts at ptr[j], ascending modulo NPORTS; first requester wins.
REQ-019 On a grant to input w, ptr[j] SHALL become (w+1) mod NPORTS next cycle; without a grant ptr[j] SHALL hold.
REQ-020 in_ready[i] SHALL be 1 in the same cycle input i is granted by any output, else 0; at most one grant per input (one-hot labels).
REQ-021 U-turn (i==j) SHALL be permitted; no routing-legality checks inside this block.
REQ-022 Latency SHALL be 1 cycle: out_valid[j]/out_data[j] on edge after grant carry the winner's flit.
REQ-023 Without a grant, out_valid[j] SHALL be 0 next cycle and out_data[j] SHALL hold its previous value.
REQ-024 credit_cnt[j] SHALL decrement on grant, increment on credit_in[j], hold if both or neither.
REQ-025 credit_in[j] with credit_cnt[j]==CREDITS and no same-cycle grant SHALL be ignored and set err[1].
REQ-026 Grant with credit_cnt[j]==1 and credit_in[j] SHALL leave count at 1; output remains eligible next cycle.
REQ-027 Back-to-back grants to the same output SHALL be allowed every cycle while credits remain; full throughput NPORTS flits/cycle.
REQ-028 err bits SHALL stay set until reset.

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, ptr[j]=0, credit_cnt[j]=CREDITS, err=0; in_ready SHALL be forced 0.
REQ-030 Reset asserted mid-operation SHALL discard pending grants immediately; first grant possible in first cycle after rst falls.

Verification
REQ-031 Single flow: input 1 dst=00100 data=0xA5 -> in_ready[1]=1 same cycle, out_valid[2]=1 data=0xA5 next cycle, credit_cnt[2]=7.
REQ-032 Contention: inputs 0,1,3 all to output 4 continuously, no credit_in -> grants 0,1,3,0,1,3,0,1 then stall with credit_cnt[4]=0, in_ready all 0.
REQ-033 Credit restore: from REQ-032 end, pulse credit_in[4] once -> exactly one further grant (input 3), count back to 0.
REQ-034 Simultaneous grant and credit_in on output 2 at count 1 -> count stays 1, grant issued next cycle too.
REQ-035 Errors: in_dst[0]=00110 -> no grant, err[0]=1; credit_in[3] at count 8 -> count 8, err[1]=1; both clear only on rst.
REQ-036 Reset mid-stream: assert rst during REQ-032 -> out_valid=0, counts=8, pointers 0; after release input 0 granted first.
